// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Purpose : UART transmit stage. Accepts one data word per valid/ready
//             handshake and shifts it out as a frame: start bit, data
//             LSB-first, optional parity, STOP_BITS stop bits. All bit timing
//             comes from the external baud_tick pulse; there is no divider.
//   Latency : handshake to start-bit edge is one SYNC wait (up to one baud
//             period) so the start bit is always a full period long.
//   Backpressure: tx_ready is high only in IDLE; tx_data/tx_valid are ignored
//             while a frame is in flight.
//   Config  : `define UART_TX_PARITY_EN adds the PARITY state and parity bit
//             (even when PARITY_ODD=0, odd when PARITY_ODD=1). Without it the
//             frame has no parity bit and PARITY_ODD is ignored.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high; drops any partial frame
//   baud_tick  one-clk pulse per bit period
//   tx_data    word to send, sampled on the handshake edge
//   tx_valid   upstream has a word
//   tx_ready   block can accept (IDLE only)
//   tx         registered serial line, idle high
//   tx_busy    high whenever the FSM is not in IDLE
//   tx_done    one-clk pulse on the first cycle back in IDLE
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  // Stop-bit counter is a single bit, enough for one or two stop bits.
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  // Parameter legality, caught at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  localparam logic      PAR_INV = 1'(PARITY_ODD);
  logic                 parity_q, parity_d;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // baud_tick is deliberately ignored here: a tick on the handshake
        // edge only moves us to SYNC, so the start bit waits for the next
        // tick and is a full period long.
        if (tx_valid && tx_ready_q) begin
          state_d = S_SYNC;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the word as accepted; later tx_data
          // changes cannot affect it.
          parity_d = (^tx_data) ^ PAR_INV;
`endif
        end
      end

      S_SYNC: begin
        if (baud_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d    = S_PARITY;
            tx_d       = parity_q;
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            // shift_q[0] is on the line now; bit 1 goes out next.
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif

      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d   = S_IDLE;
            tx_d      = 1'b1;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with state_q on every cycle.
    tx_ready_d = (state_d == S_IDLE);
    tx_busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (A: 1 stop bit, even parity;
// B: 2 stop bits, odd parity) share one clock and a 1-in-16 baud tick.
// Expected frames are queued at each handshake and checked bit by bit by a
// line monitor on whichever instance is selected.
module tb_uart_tx_serializer;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       baud_tick = 1'b0;
  logic       sel       = 1'b0;   // 0 = instance A, 1 = instance B
  logic       drv_valid = 1'b0;
  logic [7:0] drv_data  = 8'h00;

  logic tx_valid_a, tx_ready_a, tx_a, tx_busy_a, tx_done_a;
  logic tx_valid_b, tx_ready_b, tx_b, tx_busy_b, tx_done_b;
  logic mon_tx, mon_ready, mon_busy, mon_done;

  assign tx_valid_a = drv_valid & ~sel;
  assign tx_valid_b = drv_valid &  sel;
  assign mon_tx     = sel ? tx_b       : tx_a;
  assign mon_ready  = sel ? tx_ready_b : tx_ready_a;
  assign mon_busy   = sel ? tx_busy_b  : tx_busy_a;
  assign mon_done   = sel ? tx_done_b  : tx_done_a;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(drv_data),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a),
    .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(drv_data),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  always #5 clk = ~clk;

  // baud_tick high for one clk in every 16, changed on the falling edge.
  initial begin : tick_gen
    int tick_cnt;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      tick_cnt  = (tick_cnt + 1) % 16;
      baud_tick = (tick_cnt == 0);
    end
  end

  typedef struct {
    logic [15:0] bits;   // bit i = i-th bit on the line (bit 0 = start)
    int          len;
  } frame_t;

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    bit          keep;   // leave tx_valid high into the next entry
    logic [15:0] bits;
    int          len;
  } vec_t;

  frame_t exp_q[$];
  int     checks      = 0;
  int     errors      = 0;
  int     frames_seen = 0;
  int     frames_sent = 0;
  bit     mon_active  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Line monitor: a low sample while out of reset starts a frame; every bit
  // must hold for exactly 16 samples, tx_busy stays high and tx_done low
  // until the sample right after the last stop bit.
  initial begin : monitor
    frame_t      f;
    logic [15:0] got;
    bit          width_ok, busy_ok, early_done, aborted;
    forever begin
      @(negedge clk);
      if (!reset && mon_tx === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit with nothing queued (t=%0t)", $time);
          f.bits = '0;
          f.len  = 10;
        end else begin
          f = exp_q.pop_front();
        end
        got = '0; width_ok = 1'b1; busy_ok = 1'b1; early_done = 1'b0; aborted = 1'b0;
        for (int i = 0; i < f.len * 16; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (i % 16 == 0) got[i / 16] = mon_tx;
          else if (mon_tx !== got[i / 16]) width_ok = 1'b0;
          if (mon_busy !== 1'b1) busy_ok = 1'b0;
          if (mon_done !== 1'b0) early_done = 1'b1;
        end
        if (!aborted) begin
          @(negedge clk);
          chk("frame_bits", got, f.bits);
          chk("bit_widths_16clk", width_ok, 1);
          chk("busy_during_frame", busy_ok, 1);
          chk("no_early_done", early_done, 0);
          chk("done_after_last_stop", mon_done, 1);
          chk("not_busy_on_done", mon_busy, 0);
          chk("line_high_on_done", mon_tx, 1);
          frames_seen++;
        end
        mon_active = 1'b0;
      end
    end
  end

  // Offer a word until accepted, scrambling tx_data while the block is busy.
  task automatic send(input logic [7:0] d, input logic [15:0] bits, input int len, input bit keep);
    bit     ok;
    frame_t f;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      drv_valid = 1'b1;
      if (mon_ready === 1'b1) begin
        drv_data = d;
        f.bits   = bits;
        f.len    = len;
        exp_q.push_back(f);
        ok = 1'b1;
      end else begin
        drv_data = 8'($urandom);
      end
    end
    chk("send_accepted", ok, 1);
    if (!keep) begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (exp_q.size() == 0 && !mon_active), 1);
    chk("ready_after_frame", mon_ready, 1);
    chk("idle_after_frame", mon_busy, 0);
  endtask

`ifdef UART_TX_PARITY_EN
  localparam int N_VEC = 8;
`else
  localparam int N_VEC = 4;
`endif

  initial begin : main
    vec_t        tbl[N_VEC];
    int          lat;
    logic [15:0] f69, f3c, f81;
    int          flen_a;

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 16'h054A, 11};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 16'h0400, 11};
    tbl[2] = '{1'b0, 8'hFF, 1'b0, 16'h05FE, 11};
    tbl[3] = '{1'b1, 8'h55, 1'b0, 16'h0EAA, 12};
    tbl[4] = '{1'b0, 8'h07, 1'b0, 16'h060E, 11};
    tbl[5] = '{1'b0, 8'h03, 1'b0, 16'h0406, 11};
    tbl[6] = '{1'b1, 8'h07, 1'b0, 16'h0C0E, 12};
    tbl[7] = '{1'b1, 8'h03, 1'b0, 16'h0E06, 12};
    f69 = 16'h04D2; f3c = 16'h0478; f81 = 16'h0502; flen_a = 11;
`else
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 16'h034A, 10};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 16'h0200, 10};
    tbl[2] = '{1'b0, 8'hFF, 1'b0, 16'h03FE, 10};
    tbl[3] = '{1'b1, 8'h55, 1'b0, 16'h06AA, 11};
    f69 = 16'h02D2; f3c = 16'h0278; f81 = 16'h0302; flen_a = 10;
`endif

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);          chk("rst_tx_b", tx_b, 1);
    chk("rst_ready_a", tx_ready_a, 1); chk("rst_ready_b", tx_ready_b, 1);
    chk("rst_busy_a", tx_busy_a, 0);   chk("rst_busy_b", tx_busy_b, 0);
    chk("rst_done_a", tx_done_a, 0);   chk("rst_done_b", tx_done_b, 0);
    reset = 1'b0;

    // Table: plain frames, held-valid back-to-back pair, stop/parity variants.
    for (int v = 0; v < N_VEC; v++) begin
      sel = tbl[v].sel;
      send(tbl[v].data, tbl[v].bits, tbl[v].len, tbl[v].keep);
      frames_sent++;
      if (!tbl[v].keep) drain();
    end

    // Handshake on a tick edge: SYNC must still wait one full period.
    sel = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (baud_tick) break;
    end
    repeat (15) @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b1;
    drv_data  = 8'h81;
    exp_q.push_back('{f81, flen_a});
    frames_sent++;
    @(negedge clk);
    drv_valid = 1'b0;
    chk("ready_low_after_hs", tx_ready_a, 0);
    lat = 1;
    while (tx_a !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("tick_hs_start_latency", lat, 17);
    drain();

    // Reset in the middle of data bit 4 (a 0 bit of 0x69).
    send(8'h69, f69, flen_a, 1'b0);
    lat = 0;
    while (tx_a !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (5 * 16 + 7) @(negedge clk);
    chk("pre_reset_tx_low", tx_a, 0);
    chk("pre_reset_busy", tx_busy_a, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_tx_high_now", tx_a, 1);
    chk("reset_busy_low_now", tx_busy_a, 0);
    chk("reset_ready_now", tx_ready_a, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'h3C, f3c, flen_a, 1'b0);
    frames_sent++;
    drain();

    // Quiet period: any extra frame shows up as unexpected_frame.
    repeat (400) @(negedge clk);
    chk("frame_count", frames_seen, frames_sent);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
